sirv_wdog_wr_arb: RTL and testbench
===================================

// Module: sirv_wdog_wr_arb
// PURPOSE
//  Sole writer of the watchdog register bus. Arbitrates write requests from NREQ agents
//  (round-robin) and turns each one into the watchdog's two-write unlock protocol:
//  a key write of KEY, then the target write on the next cycle.
//  Sits between the bus-facing agents and the watchdog's per-register write_valid/bits inputs.
//  The top level decodes wd_wr_sel into the individual write_valid strobes.
// PARAMETERS
//  NREQ       2              number of requesting agents (1..8)
//  KEY        32'h0051F15E   unlock key value
//  MAX_RETRY  3              failed unlock attempts before a request completes with error
// PORTS
//  clock         in   1          clock
//  reset         in   1          reset, asynchronous, active-high
//  req_valid     in   NREQ       per-agent write request; held stable until the agent's ack
//  req_sel       in   3*NREQ     per-agent target: 0 cfg,1 countLo,2 countHi,3 s,4 cmp0,5 feed,6 key
//  req_data      in   32*NREQ    per-agent write data (agent i occupies bits [32*i+31:32*i])
//  ack           out  NREQ       one-cycle completion pulse to the granted agent
//  ack_err       out  1          qualifies ack: 1 = unlock never observed, target not written
//  busy          out  1          high when the FSM is not in IDLE
//  wd_unlocked   in   1          watchdog key register read bit 0 (the unlocked flag)
//  wd_wr_valid   out  1          watchdog write strobe
//  wd_wr_sel     out  3          watchdog register select (same encoding as req_sel)
//  wd_wr_data    out  32         watchdog write data
// BEHAVIOUR
//  Reset: FSM=IDLE, rr pointer=0, retry count=0; ack=0, ack_err=0, busy=0, wd_wr_valid=0.
//   wd_wr_sel=0, wd_wr_data=0.
//  All outputs are driven from registers, except wd_wr_valid in WR (see below).
//  FSM states: IDLE, KEY, WR, RESP.
//  IDLE:
//   - If any req_valid is high, grant the first requester at or after the rr pointer (wrapping).
//   - Latch the grant index, sel and data.
//   - Go to KEY, or directly to WR when sel==6 (a key write needs no unlock).
//  KEY:
//   - wd_wr_valid=1, wd_wr_sel=6, wd_wr_data=KEY. Next state: WR.
//  WR:
//   - wd_wr_valid = wd_unlocked OR (latched sel==6); wd_wr_sel and wd_wr_data come from the latch.
//   - If the write is issued: go to RESP with err=0.
//   - Else increment the retry count:
//     - if retry count + 1 == MAX_RETRY, go to RESP with err=1;
//     - otherwise go back to KEY.
//  RESP:
//   - ack[grant]=1 and ack_err=err for exactly one cycle.
//   - rr pointer <= (grant+1) mod NREQ; retry count <= 0. Next state: IDLE.
//  Latency, no retry: request seen in IDLE at cycle t -> KEY at t+1 -> WR at t+2 -> ack at t+3.
//   - Next grant is possible at t+4.
//  Key write and target write are always on consecutive cycles.
//   - Nothing else drives the bus in between, so the unlock is never consumed by another write.
//  Deasserting req_valid after the grant has no effect: the latched request completes and is acked.
//  A new request from the same agent needs req_valid high in IDLE.
//  Simultaneous requests: exactly one grant per transaction, in rr order.
//   - No agent waits more than NREQ-1 transactions.
//  Feed (sel 5): the data passes through unmodified. Agents supply 32'h0D09F00D.
//  Asynchronous reset mid-transaction: immediate return to IDLE, outputs at reset values.
//   - The pending request is dropped with no ack.
//  ack is never asserted to an agent that is not granted. At most one ack bit is high per cycle.
// TESTING
//  1. Agent0 cfg write 32'h0000_1008, unlocked follows the key write.
//     -> bus sees (6,0x51F15E) at t+1, (0,0x1008) at t+2; ack=01 at t+3; ack_err=0.
//  2. Both agents request continuously (NREQ=2).
//     -> grants alternate 0,1,0,1; acks at t+3, t+7, t+11, t+15.
//  3. wd_unlocked held 0, MAX_RETRY=3.
//     -> three KEY/WR pairs, no target write, then ack with ack_err=1; rr pointer advances.
//  4. Agent1 sel=6, data=0x51F15E.
//     -> no preceding KEY write; single bus write at t+1; ack=10 at t+2.
//  5. Assert reset during the WR cycle.
//     -> wd_wr_valid=0 and busy=0 immediately; no ack; after release, a new request completes normally.
//  6. Agent0 feed 0x0D09F00D while agent1 idle.
//     -> bus (6,KEY) then (5,0x0D09F00D); ack=01; busy high for exactly 3 cycles.

Source files
------------

// File: rtl/sirv_wdog_wr_arb_if.sv
// Agent request/ack bus plus the watchdog write port of the watchdog write arbiter.
// master = agents and watchdog (testbench side), slave = the arbiter.
interface sirv_wdog_wr_arb_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][2:0]  req_sel;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  ack_err;
  logic                  busy;
  logic                  wd_unlocked;
  logic                  wd_wr_valid;
  logic [2:0]            wd_wr_sel;
  logic [31:0]           wd_wr_data;

  modport master (
    output req_valid, req_sel, req_data, wd_unlocked,
    input  ack, ack_err, busy, wd_wr_valid, wd_wr_sel, wd_wr_data
  );

  modport slave (
    input  req_valid, req_sel, req_data, wd_unlocked,
    output ack, ack_err, busy, wd_wr_valid, wd_wr_sel, wd_wr_data
  );
endinterface

// File: rtl/sirv_wdog_wr_arb.sv
// Round-robin arbiter that is the only writer of the watchdog register bus; wraps each
// granted write in the key-then-target unlock sequence, retrying up to MAX_RETRY times.
module sirv_wdog_wr_arb #(
  parameter int          NREQ      = 2,
  parameter logic [31:0] KEY       = 32'h0051F15E,
  parameter int          MAX_RETRY = 3
) (
  input  logic              clock,
  input  logic              reset,
  sirv_wdog_wr_arb_if.slave bus
);
  localparam int         GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int         RW      = $clog2(MAX_RETRY + 1);
  localparam logic [2:0] SEL_KEY = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_WR, S_RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_grant, w_grant_nxt, r_rr, w_rr_nxt, w_pick;
  logic [2:0]      r_sel, w_sel_nxt, w_psel;
  logic [31:0]     r_data, w_data_nxt, w_pdata;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic            r_err, w_err_nxt;
  logic [NREQ-1:0] r_ack, w_ack_nxt;
  logic            r_ack_err, w_ack_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_key_wr, w_key_wr_nxt;
  logic [2:0]      r_wr_sel, w_wr_sel_nxt;
  logic [31:0]     r_wr_data, w_wr_data_nxt;
  logic            w_any, w_issue;

  // Lowest requester overall, then overridden by the lowest one at or above the rr pointer.
  always_comb begin
    w_any   = 1'b0;
    w_pick  = '0;
    w_psel  = '0;
    w_pdata = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_any   = 1'b1;
        w_pick  = GW'(i);
        w_psel  = bus.req_sel[i];
        w_pdata = bus.req_data[i];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (GW'(i) >= r_rr)) begin
        w_pick  = GW'(i);
        w_psel  = bus.req_sel[i];
        w_pdata = bus.req_data[i];
      end
    end
  end

  // The target write goes out only if the key write just before it unlocked the watchdog.
  assign w_issue = (r_state == S_WR) && (bus.wd_unlocked || (r_sel == SEL_KEY));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_data_nxt  = r_data;
    w_retry_nxt = r_retry;
    w_err_nxt   = r_err;
    w_rr_nxt    = r_rr;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_sel_nxt   = w_psel;
          w_data_nxt  = w_pdata;
          w_err_nxt   = 1'b0;
          w_state_nxt = (w_psel == SEL_KEY) ? S_WR : S_KEY;
        end
      end
      S_KEY: w_state_nxt = S_WR;
      S_WR: begin
        if (w_issue) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_retry == RW'(MAX_RETRY - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = S_KEY;
        end
      end
      S_RESP: begin
        w_rr_nxt    = (r_grant == GW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
        w_retry_nxt = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Registered outputs are computed for the state being entered.
    w_ack_nxt = '0;
    for (int i = 0; i < NREQ; i++)
      w_ack_nxt[i] = (w_state_nxt == S_RESP) && (w_grant_nxt == GW'(i));
    w_ack_err_nxt = (w_state_nxt == S_RESP) && w_err_nxt;
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_key_wr_nxt  = (w_state_nxt == S_KEY);
    w_wr_sel_nxt  = '0;
    w_wr_data_nxt = '0;
    if (w_state_nxt == S_KEY) begin
      w_wr_sel_nxt  = SEL_KEY;
      w_wr_data_nxt = KEY;
    end else if (w_state_nxt == S_WR) begin
      w_wr_sel_nxt  = w_sel_nxt;
      w_wr_data_nxt = w_data_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr      <= '0;
      r_sel     <= '0;
      r_data    <= '0;
      r_retry   <= '0;
      r_err     <= 1'b0;
      r_ack     <= '0;
      r_ack_err <= 1'b0;
      r_busy    <= 1'b0;
      r_key_wr  <= 1'b0;
      r_wr_sel  <= '0;
      r_wr_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr      <= w_rr_nxt;
      r_sel     <= w_sel_nxt;
      r_data    <= w_data_nxt;
      r_retry   <= w_retry_nxt;
      r_err     <= w_err_nxt;
      r_ack     <= w_ack_nxt;
      r_ack_err <= w_ack_err_nxt;
      r_busy    <= w_busy_nxt;
      r_key_wr  <= w_key_wr_nxt;
      r_wr_sel  <= w_wr_sel_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.ack_err     = r_ack_err;
  assign bus.busy        = r_busy;
  assign bus.wd_wr_valid = r_key_wr | w_issue;
  assign bus.wd_wr_sel   = r_wd_sel_out();
  assign bus.wd_wr_data  = r_wr_data;

  function automatic logic [2:0] r_wd_sel_out();
    return r_wr_sel;
  endfunction
endmodule

// File: tb/tb_sirv_wdog_wr_arb.sv
// Bench for sirv_wdog_wr_arb: directed scenarios plus randomized transactions, all checked
// cycle by cycle against a transaction-level model of the unlock protocol and rr arbitration.
module tb_sirv_wdog_wr_arb;
  localparam int          NREQ = 2;
  localparam logic [31:0] KEY  = 32'h0051F15E;
  localparam int          MAXR = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_rr  = 0;

  typedef struct {
    bit          v;
    logic [2:0]  s;
    logic [31:0] d;
    bit          ul;
    logic [1:0]  ack;
    bit          err;
  } exp_t;

  sirv_wdog_wr_arb_if #(.NREQ(NREQ)) bus ();

  sirv_wdog_wr_arb #(.NREQ(NREQ), .KEY(KEY), .MAX_RETRY(MAXR)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Enter at +2 in an IDLE cycle; leave at +2 in the IDLE cycle after the ack.
  task automatic run_txn(input logic [1:0] vld, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [2:0] ulb,
                         input bit drop, output int g, output int ack_at, output int nkey,
                         output int ntgt, output int nbusy);
    exp_t        q[$];
    exp_t        e;
    logic [2:0]  s;
    logic [31:0] d;
    bit          ok;
    bus.req_valid   = vld;
    bus.req_sel[0]  = s0;
    bus.req_sel[1]  = s1;
    bus.req_data[0] = d0;
    bus.req_data[1] = d1;
    g = 0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (((vld >> ((m_rr + k) % NREQ)) & 2'd1) != 0) g = (m_rr + k) % NREQ;
    s = (g == 0) ? s0 : s1;
    d = (g == 0) ? d0 : d1;
    ok = 1'b0;
    if (s == 3'd6) begin
      e = '{1'b1, s, d, ulb[0], 2'b00, 1'b0}; q.push_back(e);
      ok = 1'b1;
    end else begin
      for (int a = 0; a < MAXR && !ok; a++) begin
        e = '{1'b1, 3'd6, KEY, 1'b0, 2'b00, 1'b0}; q.push_back(e);
        ok = ulb[a];
        e = '{ok, s, d, ok, 2'b00, 1'b0}; q.push_back(e);
      end
    end
    e = '{1'b0, 3'd0, 32'd0, 1'b0, 2'(1 << g), !ok}; q.push_back(e);
    nkey = 0; ntgt = 0; nbusy = 0; ack_at = -1;
    foreach (q[i]) begin
      @(posedge clock); #1;
      bus.wd_unlocked = q[i].ul;
      if (drop) bus.req_valid = '0;
      #1;
      if (bus.wd_wr_valid && bus.wd_wr_sel == 3'd6) nkey++;
      else if (bus.wd_wr_valid) ntgt++;
      if (bus.busy) nbusy++;
      if (bus.ack != 2'b00) ack_at = cyc;
      n_chk++;
      if (bus.wd_wr_valid !== q[i].v) begin
        n_err++; $display("FAIL wr_valid cyc=%0d got=%b exp=%b", cyc, bus.wd_wr_valid, q[i].v);
      end
      if (q[i].v) begin
        n_chk++;
        if (bus.wd_wr_sel !== q[i].s || bus.wd_wr_data !== q[i].d) begin
          n_err++;
          $display("FAIL wr_bus cyc=%0d got=(%0d,%h) exp=(%0d,%h)", cyc, bus.wd_wr_sel,
                   bus.wd_wr_data, q[i].s, q[i].d);
        end
      end
      n_chk++;
      if (bus.ack !== q[i].ack || bus.ack_err !== q[i].err) begin
        n_err++;
        $display("FAIL ack cyc=%0d got=%b/%b exp=%b/%b", cyc, bus.ack, bus.ack_err, q[i].ack,
                 q[i].err);
      end
      n_chk++;
      if (bus.busy !== 1'b1) begin
        n_err++; $display("FAIL busy cyc=%0d got=%b exp=1", cyc, bus.busy);
      end
    end
    m_rr = (g + 1) % NREQ;
    bus.wd_unlocked = 1'b0;
    @(posedge clock); #2;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.ack !== 2'b00 || bus.wd_wr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle cyc=%0d got busy=%b ack=%b wv=%b exp 0/00/0", cyc, bus.busy, bus.ack,
               bus.wd_wr_valid);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_sel = '0; bus.req_data = '0; bus.wd_unlocked = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    n_chk++;
    if (bus.ack !== 2'b00 || bus.ack_err !== 1'b0 || bus.busy !== 1'b0 ||
        bus.wd_wr_valid !== 1'b0 || bus.wd_wr_sel !== 3'd0 || bus.wd_wr_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state got ack=%b err=%b busy=%b wv=%b sel=%0d data=%h exp all 0",
               bus.ack, bus.ack_err, bus.busy, bus.wd_wr_valid, bus.wd_wr_sel, bus.wd_wr_data);
    end
    reset = 1'b0;
    m_rr  = 0;
    @(posedge clock); #2;
  endtask

  task automatic test_back_to_back();
    int g, a, nk, nt, nb, prev;
    int exp_g[4] = '{0, 1, 0, 1};
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 3'd4, 3'd2, 32'h100 + i, 32'h200 + i, 3'b111, 1'b0, g, a, nk, nt, nb);
      n_chk++;
      if (g !== exp_g[i]) begin
        n_err++; $display("FAIL b2b_grant i=%0d got=%0d exp=%0d", i, g, exp_g[i]);
      end
      if (prev >= 0) begin
        n_chk++;
        if (a - prev !== 4) begin
          n_err++; $display("FAIL b2b_spacing i=%0d got=%0d exp=4", i, a - prev);
        end
      end
      prev = a;
    end
  endtask

  task automatic test_cfg_write();
    int g, a, nk, nt, nb, t0;
    t0 = cyc;
    run_txn(2'b01, 3'd0, 3'd0, 32'h0000_1008, 32'd0, 3'b001, 1'b0, g, a, nk, nt, nb);
    n_chk++;
    if (a - t0 !== 3 || nk !== 1 || nt !== 1) begin
      n_err++; $display("FAIL cfg_write got lat=%0d key=%0d tgt=%0d exp 3/1/1", a - t0, nk, nt);
    end
  endtask

  task automatic test_retry_err();
    int g, a, nk, nt, nb;
    run_txn(2'b01, 3'd3, 3'd0, 32'hCAFE_0003, 32'd0, 3'b000, 1'b0, g, a, nk, nt, nb);
    n_chk++;
    if (nk !== 3 || nt !== 0) begin
      n_err++; $display("FAIL retry_err got key=%0d tgt=%0d exp 3/0", nk, nt);
    end
    run_txn(2'b11, 3'd1, 3'd1, 32'h11, 32'h22, 3'b001, 1'b0, g, a, nk, nt, nb);
    n_chk++;
    if (g !== 1) begin
      n_err++; $display("FAIL retry_rr got grant=%0d exp=1", g);
    end
  endtask

  task automatic test_key_direct();
    int g, a, nk, nt, nb, t0;
    t0 = cyc;
    run_txn(2'b10, 3'd0, 3'd6, 32'd0, KEY, 3'b000, 1'b0, g, a, nk, nt, nb);
    n_chk++;
    if (a - t0 !== 2 || nk !== 1 || nt !== 0 || g !== 1) begin
      n_err++;
      $display("FAIL key_direct got lat=%0d key=%0d tgt=%0d g=%0d exp 2/1/0/1", a - t0, nk, nt, g);
    end
  endtask

  task automatic test_feed();
    int g, a, nk, nt, nb;
    run_txn(2'b01, 3'd5, 3'd0, 32'h0D09F00D, 32'd0, 3'b001, 1'b1, g, a, nk, nt, nb);
    n_chk++;
    if (nb !== 3 || nk !== 1 || nt !== 1) begin
      n_err++; $display("FAIL feed got busy=%0d key=%0d tgt=%0d exp 3/1/1", nb, nk, nt);
    end
  endtask

  task automatic test_reset_mid();
    int g, a, nk, nt, nb;
    bus.req_valid = 2'b01; bus.req_sel[0] = 3'd4; bus.req_data[0] = 32'h5A5A_0004;
    @(posedge clock);
    @(posedge clock); #1;
    bus.wd_unlocked = 1'b1;
    #1;
    n_chk++;
    if (bus.wd_wr_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_pre got wv=%b exp=1", bus.wd_wr_valid);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (bus.wd_wr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset got wv=%b busy=%b ack=%b exp 0/0/00", bus.wd_wr_valid, bus.busy,
               bus.ack);
    end
    bus.req_valid = '0; bus.wd_unlocked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #2;
      n_chk++;
      if (bus.ack !== 2'b00) begin
        n_err++; $display("FAIL mid_noack i=%0d got=%b exp=00", i, bus.ack);
      end
    end
    reset = 1'b0;
    m_rr  = 0;
    @(posedge clock); #2;
    run_txn(2'b11, 3'd2, 3'd3, 32'h7777_0002, 32'h8888_0003, 3'b010, 1'b0, g, a, nk, nt, nb);
    n_chk++;
    if (g !== 0 || nt !== 1) begin
      n_err++; $display("FAIL mid_after got g=%0d tgt=%0d exp 0/1", g, nt);
    end
  endtask

  task automatic test_random();
    int g, a, nk, nt, nb;
    for (int i = 0; i < 40; i++)
      run_txn(2'($urandom_range(1, 3)), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 6)),
              $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              g, a, nk, nt, nb);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_back_to_back();
    test_cfg_write();
    test_retry_err();
    test_key_direct();
    test_feed();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
